// File: rtl/multicycle_control.sv
// Main control FSM for the 16-bit multi-cycle processor: decodes state into
// ALU-path selects and write enables, and counts fetched instructions.
module multicycle_control #(
    parameter int         COUNT_WIDTH = 16,
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             input_Opcode,
    input  logic                   input_Zero,
    input  logic                   input_negative,
    output logic [2:0]             output_ALUOp,
    output logic [1:0]             output_ALUSrcA,
    output logic [1:0]             output_ALUSrcB,
    output logic                   output_PCSrc,
    output logic                   output_PCWrite,
    output logic                   output_IorD,
    output logic                   output_MemRead,
    output logic                   output_MemWrite,
    output logic                   output_IRWrite,
    output logic                   output_RegWrite,
    output logic                   output_MemToReg,
    output logic                   output_RegDst,
    output logic [3:0]             output_State,
    output logic                   output_Halted,
    output logic [COUNT_WIDTH-1:0] output_InstrCount
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    state_t                 state, state_next;
    logic [3:0]             opcode_q;
    logic [COUNT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            count    <= '0;
            opcode_q <= '0;
        end else begin
            state <= state_next;
            if (state == S_FETCH)
                count <= count + COUNT_WIDTH'(1);
            // Opcode is captured once; later states never look at the live IR bits
            if (state == S_DECODE)
                opcode_q <= input_Opcode;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if (input_Opcode == HALT_OPCODE)
                    state_next = S_HALT;
                else begin
                    case (input_Opcode)
                        4'd0, 4'd1, 4'd2, 4'd3: state_next = S_EXEC_R;
                        4'd4:                   state_next = S_EXEC_I;
                        4'd5, 4'd6:             state_next = S_MEM_ADDR;
                        4'd7, 4'd8, 4'd9:       state_next = S_BRANCH;
                        4'd10:                  state_next = S_JUMP;
                        default:                state_next = S_FETCH;
                    endcase
                end
            end
            S_EXEC_R:   state_next = S_ALU_WB;
            S_EXEC_I:   state_next = S_ALU_WB;
            S_MEM_ADDR: state_next = (opcode_q == 4'd5) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_next = S_MEM_WB;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        output_ALUOp    = 3'd0;
        output_ALUSrcA  = 2'd0;
        output_ALUSrcB  = 2'd0;
        output_PCSrc    = 1'b0;
        output_PCWrite  = 1'b0;
        output_IorD     = 1'b0;
        output_MemRead  = 1'b0;
        output_MemWrite = 1'b0;
        output_IRWrite  = 1'b0;
        output_RegWrite = 1'b0;
        output_MemToReg = 1'b0;
        output_RegDst   = 1'b0;
        case (state)
            S_FETCH: begin
                output_MemRead = 1'b1;
                output_IRWrite = 1'b1;
                output_ALUSrcB = 2'd1;
                output_PCWrite = 1'b1;
            end
            S_DECODE: output_ALUSrcB = 2'd2;
            S_EXEC_R: begin
                output_ALUSrcA = 2'd2;
                output_ALUOp   = opcode_q[2:0];
            end
            S_EXEC_I, S_MEM_ADDR: begin
                output_ALUSrcA = 2'd2;
                output_ALUSrcB = 2'd2;
            end
            S_ALU_WB: begin
                output_RegWrite = 1'b1;
                output_RegDst   = (opcode_q <= 4'd3);
            end
            S_MEM_RD: begin
                output_IorD    = 1'b1;
                output_MemRead = 1'b1;
            end
            S_MEM_WB: begin
                output_RegWrite = 1'b1;
                output_MemToReg = 1'b1;
            end
            S_MEM_WR: begin
                output_IorD     = 1'b1;
                output_MemWrite = 1'b1;
            end
            S_BRANCH: begin
                output_ALUSrcA = 2'd2;
                output_ALUOp   = 3'd1;
                output_PCSrc   = 1'b1;
                case (opcode_q)
                    4'd7:    output_PCWrite = input_Zero;
                    4'd8:    output_PCWrite = ~input_Zero;
                    4'd9:    output_PCWrite = input_negative;
                    default: output_PCWrite = 1'b0;
                endcase
            end
            S_JUMP: begin
                output_PCSrc   = 1'b1;
                output_PCWrite = 1'b1;
            end
            default: ;
        endcase
        // Reset cycle must never commit a write, even mid-instruction
        if (reset) begin
            output_ALUOp    = 3'd0;
            output_ALUSrcA  = 2'd0;
            output_ALUSrcB  = 2'd0;
            output_PCSrc    = 1'b0;
            output_PCWrite  = 1'b0;
            output_IorD     = 1'b0;
            output_MemRead  = 1'b0;
            output_MemWrite = 1'b0;
            output_IRWrite  = 1'b0;
            output_RegWrite = 1'b0;
            output_MemToReg = 1'b0;
            output_RegDst   = 1'b0;
        end
    end

    assign output_State      = state;
    assign output_Halted     = (state == S_HALT);
    assign output_InstrCount = count;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main control FSM for the 16-bit multi-cycle processor.
- Sits directly upstream of the calculations stage (operand registers, ALUSrcA/B muxes, ALU, ALUOut register, PCSrc mux).
- Each cycle it drives the ALU-path selects and op code, plus the PC, instruction-register, memory and register-file enables, from the latched opcode and the ALU flags fed back by that stage.
- Also keeps a retired-instruction counter and a halt indicator.

Parameters:
- COUNT_WIDTH, 16, width of output_InstrCount.
- HALT_OPCODE, 4'hF, opcode that parks the FSM in HALT.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- input_Opcode  input  4  instruction bits [15:12] from the instruction register.
- input_Zero  input  1  ALU zero flag (combinational, same cycle).
- input_negative  input  1  ALU negative flag (combinational, same cycle).
- output_ALUOp  output  3  000 ADD, 001 SUB, 010 AND, 011 OR, others unused.
- output_ALUSrcA  output  2  0 PC, 1 const 2, 2 A register.
- output_ALUSrcB  output  2  0 B register, 1 const 2, 2 immediate.
- output_PCSrc  output  1  0 live ALU result, 1 ALUOut register.
- output_PCWrite  output  1  PC load enable.
- output_IorD  output  1  memory address: 0 PC, 1 ALUOut.
- output_MemRead  output  1  memory read strobe.
- output_MemWrite  output  1  memory write strobe.
- output_IRWrite  output  1  instruction register load.
- output_RegWrite  output  1  register-file write enable.
- output_MemToReg  output  1  writeback source: 0 ALUOut, 1 memory data register.
- output_RegDst  output  1  destination: 0 rt (I-type), 1 rd (R-type).
- output_State  output  4  current state code (debug).
- output_Halted  output  1  high while in HALT.
- output_InstrCount  output  COUNT_WIDTH  number of FETCH cycles since reset.

Behaviour:
- Opcodes: 0-3 R-type ADD/SUB/AND/OR; 4 ADDI; 5 LW; 6 SW; 7 BEQ; 8 BNE; 9 BLT; A JUMP; HALT_OPCODE halt; all others illegal.
- Illegal opcodes are treated as NOP: DECODE returns to FETCH.
- State codes: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WB 6, MEM_WR 7, ALU_WB 8, BRANCH 9, JUMP 10, HALT 11.
- Outputs are pure decodes of state (plus flags for PCWrite in BRANCH). Any output not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0, IRWrite=1, SrcA=0, SrcB=1, ALUOp=ADD, PCSrc=0, PCWrite=1.
  - Count increments.
  - Next state: DECODE.
- DECODE:
  - SrcA=0, SrcB=2, ALUOp=ADD, so ALUOut captures the branch/jump target.
  - Next state by opcode: R→EXEC_R; ADDI→EXEC_I; LW/SW→MEM_ADDR; BEQ/BNE/BLT→BRANCH; JUMP→JUMP; HALT_OPCODE→HALT; illegal→FETCH.
- EXEC_R: SrcA=2, SrcB=0, ALUOp=opcode[2:0]. Next: ALU_WB with RegDst=1.
- EXEC_I: SrcA=2, SrcB=2, ADD. Next: ALU_WB with RegDst=0.
- ALU_WB:
  - RegWrite=1, MemToReg=0.
  - RegDst=1 when the latched opcode is 0-3, otherwise 0.
  - Next: FETCH.
- MEM_ADDR: SrcA=2, SrcB=2, ADD. Next: MEM_RD for LW, MEM_WR for SW.
- MEM_RD: IorD=1, MemRead=1. Next: MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1, RegDst=0. Next: FETCH.
- MEM_WR: IorD=1, MemWrite=1. Next: FETCH.
- BRANCH:
  - SrcA=2, SrcB=0, SUB, PCSrc=1.
  - PCWrite = Zero (BEQ), ~Zero (BNE), negative (BLT).
  - Next: FETCH.
- JUMP: PCSrc=1, PCWrite=1. Next: FETCH.
- HALT:
  - All enables 0; output_Halted=1.
  - Remains in HALT regardless of input_Opcode until reset.
- Cycle counts: R/ADDI 4, LW 5, SW 4, branch 3, jump 3, illegal 2.
- Opcode handling: the opcode is sampled only in DECODE; MEM_ADDR and ALU_WB use a copy registered in DECODE. Later changes on input_Opcode are ignored.
- Reset:
  - While reset=1, all enables and strobes are forced to 0 combinationally and selects are 0.
  - At the edge: state←FETCH, count←0, opcode copy←0, Halted←0.
  - Reset mid-instruction abandons it; no write enable may assert in the reset cycle.
  - Reset has priority over every transition.
- Counter: wraps from all-ones to 0. It does not increment in HALT or during reset.

Test Plan:
- Reset held 2 cycles then released, opcode=0 → State 0→1→2→8→0. IRWrite=1 only in FETCH. RegWrite=1 with RegDst=1 only in cycle 4. InstrCount=1 after first FETCH.
- LW (5) → states 0,1,4,5,6. IorD=1 and MemRead=1 in MEM_RD. MemToReg=1 and RegWrite=1 in MEM_WB. SW (6) → 0,1,4,7 with MemWrite=1 in exactly one cycle.
- BEQ with Zero=1 → PCWrite=1, PCSrc=1 in BRANCH. Repeat with Zero=0 → PCWrite=0. BLT with negative=1 → PCWrite=1.
- Opcode 4'hB (illegal) → FETCH, DECODE, FETCH; no RegWrite or MemWrite ever asserted.
- Opcode 4'hF → HALT after DECODE; Halted=1 and InstrCount frozen for 20 cycles while opcode toggles; reset → State=0, Halted=0, InstrCount=0.
- Reset asserted in MEM_WR and in ALU_WB → MemWrite=0 and RegWrite=0 in that cycle; FETCH on the next cycle. Force count to 16'hFFFF, then one FETCH → count 0.
